// File: rtl/vga_ext_palette_if.sv
// Host-side DAC register port of the VGA palette: indexed, auto-incrementing
// read/write access (3C7/3C8/3C9 style) plus the DAC mode readback.
interface vga_ext_palette_if;
  logic       read_i;
  logic       write_i;
  logic       rd_addr_set_i;
  logic       wr_addr_set_i;
  logic [7:0] raddr_i;
  logic [7:0] waddr_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic [1:0] readmode_o;

  modport master (
    output read_i, write_i, rd_addr_set_i, wr_addr_set_i,
    output raddr_i, waddr_i, data_i,
    input  data_o, readmode_o
  );

  modport slave (
    input  read_i, write_i, rd_addr_set_i, wr_addr_set_i,
    input  raddr_i, waddr_i, data_i,
    output data_o, readmode_o
  );
endinterface

// File: rtl/vga_ext_palette.sv
// 256 x 24-bit VGA colour palette: host-loaded through auto-incrementing DAC
// ports, looked up by the display pipeline with a fixed two-cycle latency.
module vga_ext_palette #(
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  vga_ext_palette_if.slave        host,
  input  logic                    de_i,
  input  logic [7:0]              pel_mask_i,
  input  logic [7:0]              colour_i,
  output logic                    de_o,
  output logic [7:0]              red_o,
  output logic [7:0]              green_o,
  output logic [7:0]              blue_o
);

  localparam int unsigned ENTRIES   = 256;
  localparam int unsigned COMP_W    = 8;
  localparam int unsigned IDX_W     = 8;
  localparam logic [1:0]  MODE_WR   = 2'b00;
  localparam logic [1:0]  MODE_RD   = 2'b11;

  typedef enum logic [1:0] {
    COMP_R = 2'd0,
    COMP_G = 2'd1,
    COMP_B = 2'd2
  } comp_e;

  function automatic comp_e comp_next(input comp_e c);
    case (c)
      COMP_R:  return COMP_G;
      COMP_G:  return COMP_B;
      default: return COMP_R;
    endcase
  endfunction

  // Three component banks; contents deliberately left unreset.
  logic [COMP_W-1:0] r_ram_r [ENTRIES];
  logic [COMP_W-1:0] r_ram_g [ENTRIES];
  logic [COMP_W-1:0] r_ram_b [ENTRIES];

  logic [IDX_W-1:0]  r_windex;
  comp_e             r_wcomp;
  logic [IDX_W-1:0]  r_rindex;
  comp_e             r_rcomp;
  logic              r_rd_pend;
  logic [1:0]        r_readmode;
  logic [COMP_W-1:0] r_data;

  logic              w_wr_en;
  logic [COMP_W-1:0] w_host_rd_byte;
  logic [IDX_W-1:0]  w_pix_idx;

  assign w_wr_en   = host.write_i && !host.wr_addr_set_i && !reset_i;
  assign w_pix_idx = colour_i & pel_mask_i;

  // Host write index / component counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_windex <= '0;
      r_wcomp  <= COMP_R;
    end else if (host.wr_addr_set_i) begin
      r_windex <= host.waddr_i;
      r_wcomp  <= COMP_R;
    end else if (host.write_i) begin
      r_wcomp <= comp_next(r_wcomp);
      if (r_wcomp == COMP_B) begin
        r_windex <= r_windex + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_wr_en) begin
      case (r_wcomp)
        COMP_R:  r_ram_r[r_windex] <= host.data_i;
        COMP_G:  r_ram_g[r_windex] <= host.data_i;
        default: r_ram_b[r_windex] <= host.data_i;
      endcase
    end
  end

  // Host read index / component counter; a pending flag defers the RAM
  // fetch one cycle so a write landing with the read event is seen.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rindex  <= '0;
      r_rcomp   <= COMP_R;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= host.rd_addr_set_i || host.read_i;
      if (host.rd_addr_set_i) begin
        r_rindex <= host.raddr_i;
        r_rcomp  <= COMP_R;
      end else if (host.read_i) begin
        r_rcomp <= comp_next(r_rcomp);
        if (r_rcomp == COMP_B) begin
          r_rindex <= r_rindex + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_host_rd_byte = '0;
    case (r_rcomp)
      COMP_R:  w_host_rd_byte = r_ram_r[r_rindex];
      COMP_G:  w_host_rd_byte = r_ram_g[r_rindex];
      default: w_host_rd_byte = r_ram_b[r_rindex];
    endcase
  end

  // Read data is held between read events; mode follows the last index load.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_data     <= '0;
      r_readmode <= MODE_WR;
    end else begin
      if (r_rd_pend) begin
        r_data <= w_host_rd_byte;
      end
      if (host.rd_addr_set_i) begin
        r_readmode <= MODE_RD;
      end else if (host.wr_addr_set_i) begin
        r_readmode <= MODE_WR;
      end
    end
  end

  assign host.data_o     = r_data;
  assign host.readmode_o = r_readmode;

  // Display path: stage 1 registers the RAM lookup, stage 2 applies blanking.
  logic [COMP_W-1:0] r_pix_r;
  logic [COMP_W-1:0] r_pix_g;
  logic [COMP_W-1:0] r_pix_b;
  logic [LATENCY-1:0] r_de_pipe;
  logic [COMP_W-1:0] r_red;
  logic [COMP_W-1:0] r_green;
  logic [COMP_W-1:0] r_blue;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pix_r <= '0;
      r_pix_g <= '0;
      r_pix_b <= '0;
    end else begin
      r_pix_r <= r_ram_r[w_pix_idx];
      r_pix_g <= r_ram_g[w_pix_idx];
      r_pix_b <= r_ram_b[w_pix_idx];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_de_pipe <= '0;
    end else begin
      r_de_pipe <= {r_de_pipe[LATENCY-2:0], de_i};
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || !r_de_pipe[0]) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_red   <= r_pix_r;
      r_green <= r_pix_g;
      r_blue  <= r_pix_b;
    end
  end

  assign de_o    = r_de_pipe[LATENCY-1];
  assign red_o   = r_red;
  assign green_o = r_green;
  assign blue_o  = r_blue;

endmodule

// File: tb/tb_vga_ext_palette.sv
// Self-checking bench for vga_ext_palette: random palette contents tracked in a
// flat 768-byte model with linear write/read pointers.
module tb_vga_ext_palette;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       de_i;
  logic [7:0] pel_mask_i;
  logic [7:0] colour_i;
  logic       de_o;
  logic [7:0] red_o;
  logic [7:0] green_o;
  logic [7:0] blue_o;

  vga_ext_palette_if host_if ();

  vga_ext_palette #(.LATENCY(2)) u_dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .host       (host_if),
    .de_i       (de_i),
    .pel_mask_i (pel_mask_i),
    .colour_i   (colour_i),
    .de_o       (de_o),
    .red_o      (red_o),
    .green_o    (green_o),
    .blue_o     (blue_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       de;
    logic [7:0] idx;
  } disp_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  logic [7:0] mem [768];
  int        m_wptr = 0;
  int        m_rptr = 0;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic host_write(input logic [7:0] d);
    host_if.write_i = 1'b1;
    host_if.data_i  = d;
    tick();
    host_if.write_i = 1'b0;
    mem[m_wptr] = d;
    m_wptr = (m_wptr + 1) % 768;
  endtask

  task automatic host_wr_set(input logic [7:0] a);
    host_if.wr_addr_set_i = 1'b1;
    host_if.waddr_i       = a;
    tick();
    host_if.wr_addr_set_i = 1'b0;
    m_wptr = 3 * int'(a);
  endtask

  task automatic read_set(input logic [7:0] a);
    host_if.rd_addr_set_i = 1'b1;
    host_if.raddr_i       = a;
    tick();
    host_if.rd_addr_set_i = 1'b0;
    tick();
    tick();
    m_rptr = 3 * int'(a);
  endtask

  task automatic read_pulse();
    host_if.read_i = 1'b1;
    tick();
    host_if.read_i = 1'b0;
    tick();
    tick();
    m_rptr = (m_rptr + 1) % 768;
  endtask

  function automatic logic [23:0] entry_rgb(input logic [7:0] idx);
    int b;
    b = 3 * int'(idx);
    return {mem[b], mem[b+1], mem[b+2]};
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    host_if.read_i = 1'b0; host_if.write_i = 1'b0;
    host_if.rd_addr_set_i = 1'b0; host_if.wr_addr_set_i = 1'b0;
    host_if.raddr_i = '0; host_if.waddr_i = '0; host_if.data_i = '0;
    de_i = 1'b0; pel_mask_i = 8'hFF; colour_i = '0;
    #65;
    tick();
    n_tests++;
    if (host_if.readmode_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_readmode: got %b expected 00", host_if.readmode_o);
    end
    n_tests++;
    if (host_if.data_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00", host_if.data_o);
    end
    n_tests++;
    if (de_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_de: got %b expected 0", de_o);
    end
    n_tests++;
    if ({red_o, green_o, blue_o} !== 24'h0) begin
      n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {red_o, green_o, blue_o});
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_write_table();
    logic [7:0] d;
    host_wr_set(8'h00);
    host_if.write_i = 1'b1;
    for (int i = 0; i < 768; i++) begin
      d = 8'($urandom);
      host_if.data_i = d;
      mem[m_wptr] = d;
      m_wptr = (m_wptr + 1) % 768;
      tick();
    end
    host_if.write_i = 1'b0;
    n_tests++;
    if (host_if.readmode_o !== 2'b00) begin
      n_fail++; $display("FAIL write_readmode: got %b expected 00", host_if.readmode_o);
    end
    // Index has wrapped: this byte lands in entry 0, red.
    host_write(8'($urandom));
  endtask

  task automatic test_read_back();
    read_set(8'hFF);
    n_tests++;
    if (host_if.readmode_o !== 2'b11) begin
      n_fail++; $display("FAIL read_readmode: got %b expected 11", host_if.readmode_o);
    end
    n_tests++;
    if (host_if.data_o !== mem[m_rptr]) begin
      n_fail++; $display("FAIL read_255_r: got %h expected %h", host_if.data_o, mem[m_rptr]);
    end
    for (int p = 0; p < 4; p++) begin
      read_pulse();
      n_tests++;
      if (host_if.data_o !== mem[m_rptr]) begin
        n_fail++; $display("FAIL read_wrap_pulse%0d: got %h expected %h", p, host_if.data_o, mem[m_rptr]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      read_set(8'($urandom));
      n_tests++;
      if (host_if.data_o !== mem[m_rptr]) begin
        n_fail++; $display("FAIL read_rand_set: got %h expected %h", host_if.data_o, mem[m_rptr]);
      end
      for (int p = 0; p < int'($urandom_range(0, 4)); p++) begin
        read_pulse();
        n_tests++;
        if (host_if.data_o !== mem[m_rptr]) begin
          n_fail++; $display("FAIL read_rand_pulse: got %h expected %h", host_if.data_o, mem[m_rptr]);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    logic [7:0] k;
    k = 8'($urandom);
    host_wr_set(k);
    for (int c = 0; c < 3; c++) host_write(8'($urandom));
    read_set(k);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (host_if.data_o !== mem[m_rptr]) begin
        n_fail++; $display("FAIL wr_then_rd_c%0d: got %h expected %h", c, host_if.data_o, mem[m_rptr]);
      end
      if (c < 2) read_pulse();
    end
  endtask

  task automatic test_addr_set_priority();
    int         old;
    logic [7:0] a;
    logic [7:0] d2;
    old = m_wptr;
    a   = 8'($urandom);
    d2  = 8'($urandom);
    host_if.wr_addr_set_i = 1'b1;
    host_if.waddr_i       = a;
    host_if.write_i       = 1'b1;
    host_if.data_i        = ~mem[old];
    tick();
    host_if.wr_addr_set_i = 1'b0;
    m_wptr = 3 * int'(a);
    host_write(d2);
    read_set(8'(old / 3));
    for (int p = 0; p < old % 3; p++) read_pulse();
    n_tests++;
    if (host_if.data_o !== mem[old]) begin
      n_fail++; $display("FAIL prio_dropped_write: got %h expected %h", host_if.data_o, mem[old]);
    end
    read_set(a);
    n_tests++;
    if (host_if.data_o !== d2) begin
      n_fail++; $display("FAIL prio_new_index: got %h expected %h", host_if.data_o, d2);
    end
  endtask

  task automatic test_reset_midwrite();
    logic [7:0] d;
    read_set(8'd10);
    host_wr_set(8'h40);
    host_write(8'($urandom));
    host_write(8'($urandom));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    m_wptr = 0;
    m_rptr = 0;
    n_tests++;
    if (host_if.readmode_o !== 2'b00) begin
      n_fail++; $display("FAIL midreset_readmode: got %b expected 00", host_if.readmode_o);
    end
    n_tests++;
    if (host_if.data_o !== 8'h00) begin
      n_fail++; $display("FAIL midreset_data: got %h expected 00", host_if.data_o);
    end
    d = 8'($urandom);
    host_write(d);
    read_pulse();
    n_tests++;
    if (host_if.data_o !== mem[1]) begin
      n_fail++; $display("FAIL midreset_rindex: got %h expected %h", host_if.data_o, mem[1]);
    end
    read_set(8'h00);
    n_tests++;
    if (host_if.data_o !== d) begin
      n_fail++; $display("FAIL midreset_windex: got %h expected %h", host_if.data_o, d);
    end
  endtask

  task automatic test_display();
    disp_t       q[$];
    disp_t       e;
    logic [24:0] exp_v;
    int          n;
    n = 256 + 64 + 3;
    pel_mask_i = 8'hFF;
    for (int t = 0; t < n; t++) begin
      if (t < 256) begin
        de_i = 1'b1; colour_i = 8'(t);
      end else if (t < 320) begin
        de_i = 1'($urandom); colour_i = 8'($urandom);
      end else begin
        de_i = 1'b0; colour_i = 8'($urandom);
      end
      q.push_back('{de: de_i, idx: colour_i & pel_mask_i});
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        exp_v = {e.de, e.de ? entry_rgb(e.idx) : 24'h0};
        n_tests++;
        if ({de_o, red_o, green_o, blue_o} !== exp_v) begin
          n_fail++; $display("FAIL display_t%0d: got %h expected %h", t, {de_o, red_o, green_o, blue_o}, exp_v);
        end
      end
    end
  endtask

  task automatic test_pel_mask();
    disp_t       q[$];
    disp_t       e;
    logic [24:0] exp_v;
    for (int t = 0; t < 36; t++) begin
      if (t == 0) begin
        de_i = 1'b1; pel_mask_i = 8'h0F; colour_i = 8'hF3;
      end else if (t < 33) begin
        de_i = 1'b1; pel_mask_i = 8'($urandom); colour_i = 8'($urandom);
      end else begin
        de_i = 1'b0;
      end
      q.push_back('{de: de_i, idx: colour_i & pel_mask_i});
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        exp_v = {e.de, e.de ? entry_rgb(e.idx) : 24'h0};
        n_tests++;
        if ({de_o, red_o, green_o, blue_o} !== exp_v) begin
          n_fail++; $display("FAIL pel_mask_t%0d: got %h expected %h", t, {de_o, red_o, green_o, blue_o}, exp_v);
        end
      end
    end
    pel_mask_i = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_write_table();
    test_read_back();
    test_write_then_read();
    test_addr_set_priority();
    test_display();
    test_pel_mask();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
